// File: rtl/jpeg_stream_framer.sv
// JPEG frame sequencer: JFIF header (ROM + spliced quant table), entropy bytes, then EOI (FF D9).
// Latency: header 1 byte per 2 cycles, entropy 1 cycle pass-through; optional 0xFF stuffing via JPEG_FRAMER_BYTE_STUFF_EN.
// Backpressure: a single output register stalls on out_ready=0; entropy input throttled through ent_ready.
module jpeg_stream_framer #(
    parameter int HDR_LEN   = 328,
    parameter int QT_OFFSET = 25,
    parameter int HDR_AW    = 9
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              frame_start,
    input  logic              frame_end,
    output logic [HDR_AW-1:0] hdr_addr,
    input  logic [7:0]        hdr_data,
    output logic              qt_req,
    input  logic              qt_gnt,
    output logic [5:0]        qt_addr,
    input  logic [7:0]        qt_data,
    input  logic              ent_valid,
    input  logic [7:0]        ent_data,
    output logic              ent_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_drop
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_FETCH,
        S_HDR_LOAD,
        S_STREAM,
        S_EOI_FF,
        S_EOI_D9,
        S_EOI_DONE
`ifdef JPEG_FRAMER_BYTE_STUFF_EN
        , S_STUFF
`endif
    } state_t;

    localparam logic [HDR_AW-1:0] QT_LO    = HDR_AW'(QT_OFFSET);
    localparam logic [HDR_AW-1:0] QT_HI    = HDR_AW'(QT_OFFSET + 64);
    localparam logic [HDR_AW-1:0] HDR_LAST = HDR_AW'(HDR_LEN - 1);

    state_t            state, state_nxt;
    logic [HDR_AW-1:0] idx, idx_nxt;
    logic              src_qt;
    logic              fresh;
    logic [7:0]        held;
    logic              end_pending;

    logic              can_load;
    logic              in_win;
    logic [7:0]        hdr_byte;
    logic              load_en;
    logic [7:0]        load_byte;
    logic              issue;
    logic              issue_qt;
    logic              clr_end;

    assign can_load   = !out_valid || out_ready;
    assign in_win     = (idx >= QT_LO) && (idx < QT_HI);
    // The read port only shows the fetched byte for one cycle; afterwards the held copy is used.
    assign hdr_byte   = fresh ? (src_qt ? qt_data : hdr_data) : held;
    assign busy       = (state != S_IDLE);
    assign frame_drop = frame_start && (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load_en   = 1'b0;
        load_byte = 8'h00;
        issue     = 1'b0;
        issue_qt  = 1'b0;
        clr_end   = 1'b0;
        hdr_addr  = '0;
        qt_req    = 1'b0;
        qt_addr   = 6'd0;
        ent_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    state_nxt = S_HDR_FETCH;
                    idx_nxt   = '0;
                end
            end
            S_HDR_FETCH: begin
                if (in_win) begin
                    qt_req  = 1'b1;
                    qt_addr = 6'(idx - QT_LO);
                    if (qt_gnt) begin
                        issue     = 1'b1;
                        issue_qt  = 1'b1;
                        state_nxt = S_HDR_LOAD;
                    end
                end else begin
                    hdr_addr  = idx;
                    issue     = 1'b1;
                    state_nxt = S_HDR_LOAD;
                end
            end
            S_HDR_LOAD: begin
                if (can_load) begin
                    load_en   = 1'b1;
                    load_byte = hdr_byte;
                    if (idx == HDR_LAST) begin
                        state_nxt = S_STREAM;
                    end else begin
                        idx_nxt   = idx + HDR_AW'(1);
                        state_nxt = S_HDR_FETCH;
                    end
                end
            end
            S_STREAM: begin
                if (end_pending) begin
                    if (can_load) state_nxt = S_EOI_FF;
                end else begin
                    ent_ready = can_load;
                    if (ent_valid && can_load) begin
                        load_en   = 1'b1;
                        load_byte = ent_data;
`ifdef JPEG_FRAMER_BYTE_STUFF_EN
                        if (ent_data == 8'hFF) state_nxt = S_STUFF;
`endif
                    end
                end
            end
`ifdef JPEG_FRAMER_BYTE_STUFF_EN
            S_STUFF: begin
                if (can_load) begin
                    load_en   = 1'b1;
                    load_byte = 8'h00;
                    state_nxt = S_STREAM;
                end
            end
`endif
            S_EOI_FF: begin
                if (can_load) begin
                    load_en   = 1'b1;
                    load_byte = 8'hFF;
                    state_nxt = S_EOI_D9;
                end
            end
            S_EOI_D9: begin
                if (can_load) begin
                    load_en   = 1'b1;
                    load_byte = 8'hD9;
                    state_nxt = S_EOI_DONE;
                end
            end
            S_EOI_DONE: begin
                // D9 sits in the output register; the frame closes when it is taken.
                if (out_ready) begin
                    clr_end   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= S_IDLE;
            idx         <= '0;
            src_qt      <= 1'b0;
            fresh       <= 1'b0;
            held        <= 8'h00;
            end_pending <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (issue) begin
                src_qt <= issue_qt;
                fresh  <= 1'b1;
            end else if (state == S_HDR_LOAD) begin
                fresh <= 1'b0;
                if (fresh) held <= hdr_byte;
            end
            if (clr_end) begin
                end_pending <= 1'b0;
            end else if (frame_end && (state != S_IDLE)) begin
                end_pending <= 1'b1;
            end
            if (load_en) begin
                out_valid <= 1'b1;
                out_data  <= load_byte;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_stream_framer.sv
// Bench for jpeg_stream_framer: frame scenarios from a vector table plus directed corner sequences.
module tb_jpeg_stream_framer;

    localparam int HDR_LEN = 328;

    logic       clock;
    logic       nreset;
    logic       frame_start;
    logic       frame_end;
    logic [8:0] hdr_addr;
    logic [7:0] hdr_data;
    logic       qt_req;
    logic       qt_gnt;
    logic [5:0] qt_addr;
    logic [7:0] qt_data;
    logic       ent_valid;
    logic [7:0] ent_data;
    logic       ent_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       frame_drop;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit rand_ready = 0;

    logic [7:0] cap[$];
    int         cap_cyc[$];
    bit         stall_pend = 0;
    logic [7:0] stall_data = 8'h00;

    typedef struct packed {
        int              ent_cnt;
        logic [0:3][7:0] ent;
        bit              coinc;
        bit              end_hdr;
        bit              rand_rdy;
        bit              qt_stall;
        int              exp_cnt;
        logic [0:7][7:0] exp;
    } vec_t;

    vec_t tbl [6];

    jpeg_stream_framer dut (
        .clock      (clock),
        .nreset     (nreset),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .hdr_addr   (hdr_addr),
        .hdr_data   (hdr_data),
        .qt_req     (qt_req),
        .qt_gnt     (qt_gnt),
        .qt_addr    (qt_addr),
        .qt_data    (qt_data),
        .ent_valid  (ent_valid),
        .ent_data   (ent_data),
        .ent_ready  (ent_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_drop (frame_drop)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Memory models: header ROM byte i = i[7:0], quant EBR byte k = 0x80|k.
    always @(posedge clock) hdr_data <= hdr_addr[7:0];
    always @(posedge clock) if (qt_gnt) qt_data <= 8'h80 | {2'b00, qt_addr};

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clock) begin
        if (!nreset) begin
            stall_pend = 0;
        end else begin
            if (stall_pend) begin
                n_cmp++;
                if (!out_valid || out_data !== stall_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: got vld=%0b dat=%02h, required vld=1 dat=%02h",
                             out_valid, out_data, stall_data);
                end
            end
            stall_pend = out_valid && !out_ready;
            stall_data = out_data;
            if (out_valid && out_ready) begin
                cap.push_back(out_data);
                cap_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] hdr_exp(input int i);
        logic [7:0] b;
        if (i >= 25 && i < 89) b = 8'h80 | 8'(i - 25);
        else b = 8'(i);
        return b;
    endfunction

    task automatic send_ent(input logic [7:0] b, input bit with_end);
        bit done;
        int t;
        done = 0;
        t = 0;
        ent_valid = 1'b1;
        ent_data  = b;
        while (!done && t < 4000) begin
            @(negedge clock);
            t++;
            if (ent_ready) begin
                frame_end = with_end;
                done = 1;
            end
        end
        @(posedge clock);
        #1;
        ent_valid = 1'b0;
        frame_end = 1'b0;
        chk("ent_accept", 32'(done), 32'd1);
    endtask

    task automatic run_frame(input int r);
        int t;
        int n;
        cap.delete();
        cap_cyc.delete();
        rand_ready = tbl[r].rand_rdy;
        qt_gnt = !tbl[r].qt_stall;
        frame_start = 1'b1;
        @(posedge clock);
        #1;
        frame_start = 1'b0;
        if (tbl[r].qt_stall) begin
            t = 0;
            do begin
                @(negedge clock);
                t++;
            end while (!qt_req && t < 200);
            for (int i = 0; i < 10; i++) begin
                chk("qt_req_held", 32'(qt_req), 32'd1);
                chk("qt_addr_stall", 32'(qt_addr), 32'd0);
                @(negedge clock);
            end
            chk("qt_stall_bytes", 32'(cap.size()), 32'd25);
            chk("qt_stall_outvld", 32'(out_valid), 32'd0);
            @(posedge clock);
            #1;
            qt_gnt = 1'b1;
        end
        if (tbl[r].end_hdr) begin
            repeat (20) @(posedge clock);
            #1;
            frame_start = 1'b1;
            @(negedge clock);
            chk("frame_drop_busy", 32'(frame_drop), 32'd1);
            @(posedge clock);
            #1;
            frame_start = 1'b0;
            frame_end = 1'b1;
            @(posedge clock);
            #1;
            frame_end = 1'b0;
        end
        for (int i = 0; i < tbl[r].ent_cnt; i++)
            send_ent(tbl[r].ent[i], tbl[r].coinc && (i == tbl[r].ent_cnt - 1));
        if (!tbl[r].end_hdr && !tbl[r].coinc) begin
            frame_end = 1'b1;
            @(posedge clock);
            #1;
            frame_end = 1'b0;
        end
        t = 0;
        while (busy && t < 5000) begin
            @(negedge clock);
            t++;
        end
        chk("frame_done", 32'(busy), 32'd0);
        chk("byte_count", 32'(cap.size()), 32'(HDR_LEN + tbl[r].exp_cnt));
        n = (cap.size() < HDR_LEN + tbl[r].exp_cnt) ? cap.size() : HDR_LEN + tbl[r].exp_cnt;
        for (int i = 0; i < n; i++) begin
            if (i < HDR_LEN) chk($sformatf("hdr_byte[%0d]", i), 32'(cap[i]), 32'(hdr_exp(i)));
            else chk($sformatf("tail_byte[%0d]", i - HDR_LEN), 32'(cap[i]),
                     32'(tbl[r].exp[i - HDR_LEN]));
        end
        if (!tbl[r].rand_rdy && !tbl[r].qt_stall && cap_cyc.size() >= HDR_LEN)
            chk("hdr_rate", 32'(cap_cyc[HDR_LEN - 1] - cap_cyc[0]), 32'(2 * (HDR_LEN - 1)));
        rand_ready = 0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        tbl[0] = '{ent_cnt: 3, ent: {8'h12, 8'h34, 8'h56, 8'h00}, coinc: 0, end_hdr: 0,
                   rand_rdy: 0, qt_stall: 0, exp_cnt: 5,
                   exp: {8'h12, 8'h34, 8'h56, 8'hFF, 8'hD9, 8'h00, 8'h00, 8'h00}};
        tbl[1] = tbl[0];
        tbl[1].rand_rdy = 1;
        tbl[2] = '{ent_cnt: 0, ent: '0, coinc: 0, end_hdr: 1, rand_rdy: 0, qt_stall: 0,
                   exp_cnt: 2, exp: {8'hFF, 8'hD9, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        tbl[4] = '{ent_cnt: 1, ent: {8'hAB, 8'h00, 8'h00, 8'h00}, coinc: 0, end_hdr: 0,
                   rand_rdy: 0, qt_stall: 1, exp_cnt: 3,
                   exp: {8'hAB, 8'hFF, 8'hD9, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
`ifdef JPEG_FRAMER_BYTE_STUFF_EN
        tbl[3] = '{ent_cnt: 3, ent: {8'h12, 8'hFF, 8'h34, 8'h00}, coinc: 1, end_hdr: 0,
                   rand_rdy: 0, qt_stall: 0, exp_cnt: 6,
                   exp: {8'h12, 8'hFF, 8'h00, 8'h34, 8'hFF, 8'hD9, 8'h00, 8'h00}};
        tbl[5] = '{ent_cnt: 2, ent: {8'hFF, 8'hFF, 8'h00, 8'h00}, coinc: 1, end_hdr: 0,
                   rand_rdy: 1, qt_stall: 0, exp_cnt: 6,
                   exp: {8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hD9, 8'h00, 8'h00}};
`else
        tbl[3] = '{ent_cnt: 3, ent: {8'h12, 8'hFF, 8'h34, 8'h00}, coinc: 1, end_hdr: 0,
                   rand_rdy: 0, qt_stall: 0, exp_cnt: 5,
                   exp: {8'h12, 8'hFF, 8'h34, 8'hFF, 8'hD9, 8'h00, 8'h00, 8'h00}};
        tbl[5] = '{ent_cnt: 2, ent: {8'hFF, 8'hFF, 8'h00, 8'h00}, coinc: 1, end_hdr: 0,
                   rand_rdy: 1, qt_stall: 0, exp_cnt: 4,
                   exp: {8'hFF, 8'hFF, 8'hFF, 8'hD9, 8'h00, 8'h00, 8'h00, 8'h00}};
`endif

        // Reset held with active-looking inputs.
        nreset      = 1'b0;
        frame_start = 1'b1;
        frame_end   = 1'b0;
        ent_valid   = 1'b1;
        ent_data    = 8'h5A;
        qt_gnt      = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_hdr_addr", 32'(hdr_addr), 32'd0);
        chk("rst_qt_req", 32'(qt_req), 32'd0);
        chk("rst_qt_addr", 32'(qt_addr), 32'd0);
        chk("rst_ent_ready", 32'(ent_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_drop", 32'(frame_drop), 32'd0);
        @(posedge clock);
        #1;
        frame_start = 1'b0;
        ent_valid   = 1'b0;
        nreset      = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        for (int r = 0; r < 6; r++) run_frame(r);

        // Reset in the middle of a header: everything returns to idle values at once.
        frame_start = 1'b1;
        @(posedge clock);
        #1;
        frame_start = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        nreset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_hdr_addr", 32'(hdr_addr), 32'd0);
        @(posedge clock);
        #1;
        nreset = 1'b1;
        @(posedge clock);
        #1;
        run_frame(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
